// File: rtl/ram_arb_pkg.sv
// Shared constants and state encoding for the RAM channel arbiter.
// The default sizing matches the flash controller build with 19 channels.
package ram_arb_pkg;

   localparam int DEF_NUM_CH   = 19;
   localparam int DEF_CH_W     = 8;
   localparam int DEF_MAX_HOLD = 1024;
   localparam int DEF_CNT_W    = 11;

   // Channel index value meaning "no owner"; never a legal channel number.
   localparam logic [7:0] CH_IDLE = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_e;

   // Next round-robin start position after a channel gives up ownership.
   function automatic int unsigned wrapInc(input int unsigned idx, input int unsigned numCh);
      return (idx + 1 >= numCh) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/ram_channel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr_i,
// wrapping from NUM_CH-1 back to 0.
module rr_pick
   import ram_arb_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CH_W   = DEF_CH_W
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic              found_o,
   output logic [CH_W-1:0]   idx_o
);

   logic [NUM_CH-1:0] rotReq;
   int unsigned       offset;
   int unsigned       sum;

   // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
   always_comb begin
      rotReq  = NUM_CH'({req_i, req_i} >> ptr_i);
      found_o = 1'b0;
      offset  = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!found_o && rotReq[k]) begin
            found_o = 1'b1;
            offset  = k;
         end
      end
      sum = 32'(ptr_i) + offset;
      if (sum >= 32'(NUM_CH)) begin
         sum = sum - 32'(NUM_CH);
      end
      idx_o = CH_W'(sum);
   end

endmodule

// File: rtl/ram_channel_arbiter.sv
// Round-robin owner of the shared data RAM port: registered channel index and
// one-hot grant, released on done, request drop or hold-limit expiry.
module ram_channel_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int CH_W     = DEF_CH_W,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req,
   input  logic              done,
   output logic [CH_W-1:0]   channel,
   output logic [NUM_CH-1:0] grant,
   output logic              busy,
   output logic              timeout_err,
   output logic [CH_W-1:0]   rr_ptr_dbg
);

   arb_state_e        state_q, state_d;
   logic [CH_W-1:0]   channel_q, channel_d;
   logic [NUM_CH-1:0] grant_q, grant_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;
   logic [CH_W-1:0]   rrPtr_q, rrPtr_d;
   logic [CNT_W-1:0]  holdCnt_q, holdCnt_d;

   logic              pickFound;
   logic [CH_W-1:0]   pickIdx;
   logic              ownerReq;
   logic              release_w;
   logic              expire_w;

   rr_pick #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_rr_pick (
      .req_i   (req),
      .ptr_i   (rrPtr_q),
      .found_o (pickFound),
      .idx_o   (pickIdx)
   );

   // The grant vector is one-hot on the owner, so masking req with it tests req[channel].
   assign ownerReq  = |(req & grant_q);
   assign release_w = done || !ownerReq;
   assign expire_w  = (holdCnt_q == CNT_W'(MAX_HOLD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         channel_q <= CH_W'(CH_IDLE);
         grant_q   <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         rrPtr_q   <= '0;
         holdCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         channel_q <= channel_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         rrPtr_q   <= rrPtr_d;
         holdCnt_q <= holdCnt_d;
      end
   end

   // IDLE and GAP arbitrate identically; GAP exists only to force one ownerless cycle.
   always_comb begin
      state_d   = state_q;
      channel_d = channel_q;
      grant_d   = grant_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      rrPtr_d   = rrPtr_q;
      holdCnt_d = holdCnt_q;

      case (state_q)
         ST_IDLE, ST_GAP: begin
            if (pickFound) begin
               state_d   = ST_GRANT;
               channel_d = pickIdx;
               grant_d   = NUM_CH'(1) << pickIdx;
               busy_d    = 1'b1;
               holdCnt_d = '0;
            end else begin
               state_d   = ST_IDLE;
               channel_d = CH_W'(CH_IDLE);
               grant_d   = '0;
               busy_d    = 1'b0;
            end
         end

         ST_GRANT: begin
            if (release_w || expire_w) begin
               state_d   = ST_GAP;
               channel_d = CH_W'(CH_IDLE);
               grant_d   = '0;
               busy_d    = 1'b0;
               timeout_d = expire_w && !release_w;
               rrPtr_d   = CH_W'(wrapInc(32'(channel_q), NUM_CH));
               holdCnt_d = '0;
            end else if (holdCnt_q != {CNT_W{1'b1}}) begin
               holdCnt_d = holdCnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d   = ST_IDLE;
            channel_d = CH_W'(CH_IDLE);
            grant_d   = '0;
            busy_d    = 1'b0;
            holdCnt_d = '0;
         end
      endcase
   end

   assign channel     = channel_q;
   assign grant       = grant_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_q;
   assign rr_ptr_dbg  = rrPtr_q;

endmodule

// File: tb/tb_ram_channel_arbiter.sv
// Bench for ram_channel_arbiter: directed request/done sequences checked every
// cycle against an ownership model, plus hand-computed literal expectations.
module tb_ram_channel_arbiter;

   localparam int NumCh   = 19;
   localparam int ChW     = 8;
   localparam int MaxHold = 8;
   localparam int CntW    = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [NumCh-1:0] req = '0;
   logic             done = 1'b0;
   logic [ChW-1:0]   channel;
   logic [NumCh-1:0] grant;
   logic             busy;
   logic             timeoutErr;
   logic [ChW-1:0]   rrPtrDbg;

   int checks = 0;
   int errors = 0;

   int   mOwner = -1;
   int   mPtr = 0;
   int   mHeld = 0;
   logic mTimeout = 1'b0;

   int   cnt;

   always #5 clk = ~clk;

   ram_channel_arbiter #(
      .NUM_CH   (NumCh),
      .CH_W     (ChW),
      .MAX_HOLD (MaxHold),
      .CNT_W    (CntW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .channel     (channel),
      .grant       (grant),
      .busy        (busy),
      .timeout_err (timeoutErr),
      .rr_ptr_dbg  (rrPtrDbg)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [NumCh-1:0] r, input logic d);
      req  = r;
      done = d;
   endtask

   // Ownership model: who owns the port, how long it has held it, where the next scan starts.
   always @(posedge clk or negedge rst_n) begin : model
      int   nxtOwner;
      int   nxtPtr;
      int   nxtHeld;
      logic nxtTo;
      logic rel;
      if (!rst_n) begin
         mOwner   <= -1;
         mPtr     <= 0;
         mHeld    <= 0;
         mTimeout <= 1'b0;
      end else begin
         nxtOwner = mOwner;
         nxtPtr   = mPtr;
         nxtHeld  = mHeld;
         nxtTo    = 1'b0;
         if (mOwner >= 0) begin
            nxtHeld = mHeld + 1;
            rel = done || !req[mOwner];
            if (rel || nxtHeld == MaxHold) begin
               nxtTo    = !rel;
               nxtPtr   = (mOwner + 1) % NumCh;
               nxtOwner = -1;
            end
         end else begin
            for (int k = 0; k < NumCh; k++) begin
               if (nxtOwner < 0 && req[(mPtr + k) % NumCh]) begin
                  nxtOwner = (mPtr + k) % NumCh;
                  nxtHeld  = 0;
               end
            end
         end
         mOwner   <= nxtOwner;
         mPtr     <= nxtPtr;
         mHeld    <= nxtHeld;
         mTimeout <= nxtTo;
      end
   end

   // Every falling edge the registered outputs must agree with the model.
   always @(negedge clk) begin
      checkOutput("modelChannel", 32'(channel), (mOwner < 0) ? 32'hFF : 32'(mOwner));
      checkOutput("modelGrant", 32'(grant), (mOwner < 0) ? 32'h0 : (32'h1 << mOwner));
      checkOutput("modelBusy", 32'(busy), (mOwner < 0) ? 32'h0 : 32'h1);
      checkOutput("modelTimeout", 32'(timeoutErr), 32'(mTimeout));
      checkOutput("modelRrPtr", 32'(rrPtrDbg), 32'(mPtr));
   end

   initial begin
      // Reset and idle.
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("idleChannel", 32'(channel), 32'hFF);
      checkOutput("idleGrant", 32'(grant), 32'h0);
      checkOutput("idleBusy", 32'(busy), 32'h0);

      // Single request on channel 3, released by done.
      applyStimulus(NumCh'(1) << 3, 1'b0);
      @(negedge clk);
      checkOutput("singleChannel", 32'(channel), 32'd3);
      checkOutput("singleGrant", 32'(grant), 32'h8);
      repeat (3) @(negedge clk);
      applyStimulus(NumCh'(1) << 3, 1'b1);
      @(negedge clk);
      applyStimulus('0, 1'b0);
      checkOutput("singleRelease", 32'(channel), 32'hFF);
      checkOutput("singleRrPtr", 32'(rrPtrDbg), 32'd4);
      @(negedge clk);

      // Round-robin over all channels with wrap, starting from a fresh pointer.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus({NumCh{1'b1}}, 1'b0);
      for (int g = 0; g < 20; g++) begin
         @(negedge clk);
         checkOutput("rrOrder", 32'(channel), 32'(g % NumCh));
         checkOutput("rrBusy", 32'(busy), 32'h1);
         @(negedge clk);
         applyStimulus({NumCh{1'b1}}, 1'b1);
         @(negedge clk);
         if (g == 19) applyStimulus('0, 1'b0);
         else         applyStimulus({NumCh{1'b1}}, 1'b0);
         checkOutput("rrGap", 32'(busy), 32'h0);
         if (g == 18) checkOutput("rrWrap", 32'(rrPtrDbg), 32'h0);
      end

      // Rotation skip: pointer at 17, owner 17 releases, channel 2 must follow.
      applyStimulus(NumCh'(1) << 16, 1'b0);
      @(negedge clk);
      checkOutput("rotFirst", 32'(channel), 32'd16);
      applyStimulus('0, 1'b0);
      @(negedge clk);
      checkOutput("rotPtr17", 32'(rrPtrDbg), 32'd17);
      applyStimulus((NumCh'(1) << 2) | (NumCh'(1) << 17), 1'b0);
      @(negedge clk);
      checkOutput("rotOwner17", 32'(channel), 32'd17);
      applyStimulus((NumCh'(1) << 2) | (NumCh'(1) << 17), 1'b1);
      @(negedge clk);
      applyStimulus((NumCh'(1) << 2) | (NumCh'(1) << 17), 1'b0);
      checkOutput("rotGap", 32'(busy), 32'h0);
      @(negedge clk);
      checkOutput("rotSkip", 32'(channel), 32'd2);
      applyStimulus('0, 1'b0);
      @(negedge clk);
      checkOutput("rotPtr3", 32'(rrPtrDbg), 32'd3);

      // Timeout on channel 7, then a done that coincides with the hold limit.
      applyStimulus(NumCh'(1) << 7, 1'b0);
      @(negedge clk);
      cnt = 0;
      while (busy && cnt < 20) begin
         cnt++;
         @(negedge clk);
      end
      checkOutput("timeoutLen", 32'(cnt), 32'd8);
      checkOutput("timeoutFlag", 32'(timeoutErr), 32'h1);
      checkOutput("timeoutChannel", 32'(channel), 32'hFF);
      @(negedge clk);
      checkOutput("timeoutPulse", 32'(timeoutErr), 32'h0);
      checkOutput("timeoutRegrant", 32'(channel), 32'd7);
      repeat (7) @(negedge clk);
      applyStimulus(NumCh'(1) << 7, 1'b1);
      @(negedge clk);
      applyStimulus('0, 1'b0);
      checkOutput("doneAtLimitBusy", 32'(busy), 32'h0);
      checkOutput("doneAtLimitNoFlag", 32'(timeoutErr), 32'h0);

      // Owner 9 drops req together with done while channel 12 waits.
      applyStimulus(NumCh'(1) << 9, 1'b0);
      @(negedge clk);
      checkOutput("simulOwner9", 32'(channel), 32'd9);
      applyStimulus((NumCh'(1) << 9) | (NumCh'(1) << 12), 1'b0);
      @(negedge clk);
      checkOutput("noPreempt", 32'(channel), 32'd9);
      applyStimulus(NumCh'(1) << 12, 1'b1);
      @(negedge clk);
      applyStimulus(NumCh'(1) << 12, 1'b0);
      checkOutput("simulGap", 32'(busy), 32'h0);
      @(negedge clk);
      checkOutput("simulNext12", 32'(channel), 32'd12);
      @(negedge clk);
      checkOutput("simulHold12", 32'(channel), 32'd12);
      applyStimulus('0, 1'b0);
      @(negedge clk);
      checkOutput("simulPtr13", 32'(rrPtrDbg), 32'd13);

      // Asynchronous reset in the middle of a grant on channel 5.
      applyStimulus(NumCh'(1) << 5, 1'b0);
      @(negedge clk);
      checkOutput("asyncOwner5", 32'(channel), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("asyncChannel", 32'(channel), 32'hFF);
      checkOutput("asyncGrant", 32'(grant), 32'h0);
      checkOutput("asyncBusy", 32'(busy), 32'h0);
      checkOutput("asyncRrPtr", 32'(rrPtrDbg), 32'h0);
      applyStimulus('0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_channel_arbiter.md
Name: ram_channel_arbiter

Overview:
Round-robin arbiter that decides which of the flash channels owns the shared data RAM port. It produces the registered channel index consumed by the downstream per-channel enable mux, plus a one-hot grant back to the channel controllers. Ownership is held until the owner signals done, drops its request, or exceeds a hold limit. The limit prevents a hung channel from starving the others.

Parameters:
NUM_CH, 19, number of requesting channels; legal range 1..255 (index 8'hFF reserved as "none")
CH_W, 8, width of channel index output
MAX_HOLD, 1024, max cycles one grant may be held before forced release; legal range >= 2
CNT_W, 11, width of hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_CH  per-channel RAM access request, level, held until granted and finished
done  in  1  single-cycle pulse from current owner: transfer finished, release grant
channel  out  CH_W  registered index of current owner; 8'hFF when no owner
grant  out  NUM_CH  registered one-hot grant, all-zero when no owner
busy  out  1  high while a grant is held
timeout_err  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD
rr_ptr_dbg  out  CH_W  current round-robin start pointer, for debug/coverage

Behaviour:
- Reset, asynchronous and immediate, also mid-grant: state=IDLE, channel=8'hFF, grant=0, busy=0, timeout_err=0, rr_ptr=0, hold_cnt=0.
- States: IDLE, GRANT, GAP. All outputs are registered; no combinational path from req to outputs.
- IDLE: if req!=0, pick the first set bit scanning from index rr_ptr upward, wrapping NUM_CH-1 -> 0. At that clock edge: state=GRANT, channel=idx, grant=1<<idx, busy=1, hold_cnt=0. Latency from req sampled high to grant visible is 1 cycle.
- GRANT: hold_cnt increments every cycle, saturating. Exit to GAP at the edge where any of the following is true:
  (a) done=1;
  (b) req[channel]=0;
  (c) hold_cnt==MAX_HOLD-1, which also asserts timeout_err for exactly the GAP cycle.
- Exit priority for flagging: (a) or (b) suppresses the timeout flag if it coincides with (c).
- On exit: channel=8'hFF, grant=0, busy=0, rr_ptr=(idx==NUM_CH-1)?0:idx+1.
- GAP: exactly one turnaround cycle with no owner, so the downstream mux outputs 0. GAP arbitrates exactly as IDLE using the updated rr_ptr. If no request is pending, go to IDLE.
- Back-to-back: with requests continuously pending, the grant pattern is GRANT(n cycles), GAP(1), GRANT(...). Minimum period is 2 cycles.
- done in IDLE/GAP is ignored. done and req drop in the same cycle give a single release.
- Requests asserted by non-owners during GRANT are not visible until GAP. No preemption.
- Indices >= NUM_CH never appear on channel. 8'hFF is the only idle value.
- Fairness: every requester holding req continuously is granted within NUM_CH-1 foreign grants.

Decomposition:
- Package ram_arb_pkg: CH_IDLE=8'hFF, state encoding (IDLE=2'd0, GRANT=2'd1, GAP=2'd2), default NUM_CH/MAX_HOLD.
- One sub-module, rr_pick: combinational rotate-and-priority-encode. Inputs are req and rr_ptr; outputs are found and idx. This keeps the FSM file small and lets the picker be unit-tested alone.

Test Plan:
- Reset/idle: rst_n low then high, req=0 -> channel=8'hFF, grant=0, busy=0 for 20 cycles; assert rst_n low mid-grant on ch5 -> outputs return to reset values without waiting for a clock edge.
- Single request: req[3]=1 at cycle 10 -> channel=3, grant=19'h8 at cycle 11; done pulse at cycle 15 -> channel=8'hFF at cycle 16, rr_ptr_dbg=4.
- Round-robin wrap: req=all ones, done pulsed 2 cycles after each grant -> grant order 0,1,...,18,0 with exactly one GAP cycle between grants; rr_ptr wraps 18 -> 0.
- Rotation skip: rr_ptr=17, req bits {2,17} set, owner 17 releases -> next grant is ch2, not ch17 again.
- Timeout: MAX_HOLD=8, req[7] held, no done -> release after 8 grant cycles, timeout_err high for 1 cycle, channel=8'hFF; same test with done on cycle 8 -> no timeout_err.
- Req drop and simultaneous events: owner ch9 drops req with done asserted in the same cycle -> single release, one GAP, next pending channel (ch12) granted the following cycle.
